// File: rtl/io_bus_master.sv
// Initiator for the memory-mapped IO bus: turns core load/store requests into
// single io_* bus cycles and returns lane-extracted, extended read data.
module io_bus_master #(
  parameter logic [31:0] IO_BASE = 32'h8000_0000,
  parameter logic [31:0] IO_MASK = 32'hF000_0000,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] io_addr,
  output logic        io_we,
  output logic [3:0]  io_be,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [2:0] RD_LAST = 3'(RD_LAT);

  state_t      state, state_d;
  logic [2:0]  cnt, cnt_d;
  logic        req_ready_d, rsp_valid_d, rsp_err_d, io_we_d;
  logic [31:0] rsp_rdata_d, io_addr_d, io_wdata_d;
  logic [3:0]  io_be_d;
  logic        req_err;
  logic [1:0]  size_q, off_q;
  logic        uns_q;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    lane_be = 4'b0001 << off;
      2'd1:    lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    lane_wdata = {4{wdata[7:0]}};
      2'd1:    lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  // Pick the addressed lane(s) out of the bus word, then zero- or sign-extend.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] s32;
    b8  = rdata[{off, 3'b000} +: 8];
    h16 = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0: begin
        s32 = b8;
        load_extract = uns ? {24'd0, b8} : s32;
      end
      2'd1: begin
        s32 = h16;
        load_extract = uns ? {16'd0, h16} : s32;
      end
      default: load_extract = rdata;
    endcase
  endfunction

  assign req_err = (req_size == 2'd3)
                || (req_size == 2'd1 && req_addr[0])
                || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                || ((req_addr & IO_MASK) != IO_BASE);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    io_addr_d   = io_addr;
    io_we_d     = io_we;
    io_be_d     = io_be;
    io_wdata_d  = io_wdata;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            io_addr_d = {req_addr[31:2], 2'b00};
            io_be_d   = lane_be(req_size, req_addr[1:0]);
            cnt_d     = '0;
            if (req_we) begin
              state_d    = WRITE;
              io_we_d    = 1'b1;
              io_wdata_d = lane_wdata(req_size, req_wdata);
            end else begin
              state_d    = READ;
              io_wdata_d = '0;
            end
          end
        end
      end
      WRITE: begin
        state_d     = RESP;
        io_addr_d   = '0;
        io_we_d     = 1'b0;
        io_be_d     = '0;
        io_wdata_d  = '0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      READ: begin
        // Address held RD_LAT+1 cycles; io_rdata is taken on the last edge.
        if (cnt == RD_LAST) begin
          state_d     = RESP;
          io_addr_d   = '0;
          io_be_d     = '0;
          io_wdata_d  = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_extract(io_rdata, size_q, off_q, uns_q);
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      io_addr   <= '0;
      io_we     <= 1'b0;
      io_be     <= '0;
      io_wdata  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      io_addr   <= io_addr_d;
      io_we     <= io_we_d;
      io_be     <= io_be_d;
      io_wdata  <= io_wdata_d;
    end
  end

  // Request shape kept for read-data extraction; only meaningful after a handshake.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      size_q <= req_size;
      off_q  <= req_addr[1:0];
      uns_q  <= req_unsigned;
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: directed scenarios plus randomized loads/stores
// against a byte-array reference model of the IO region.
`timescale 1ns/1ps
module tb_io_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] io_addr, io_wdata;
  logic        io_we;
  logic [3:0]  io_be;
  logic [31:0] io_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic        fixed_rd = 1'b0;
  logic [31:0] bus_mem [16];
  logic [7:0]  ref_mem [64];

  always #5 clk = ~clk;

  io_bus_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .io_addr(io_addr), .io_we(io_we), .io_be(io_be), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  // Responder: byte-enabled writes at the io_we edge, read data registered one clock after address.
  always @(posedge clk) begin
    if (io_we)
      for (int k = 0; k < 4; k++)
        if (io_be[k]) bus_mem[io_addr[5:2]][8*k +: 8] <= io_wdata[8*k +: 8];
    io_rdata <= fixed_rd ? 32'h0000_F080 : bus_mem[io_addr[5:2]];
  end

  function automatic logic ref_err(input logic [31:0] a, input logic [1:0] s);
    int unsigned nb = 1 << s;
    int unsigned aa = a;
    return (s == 2'd3) || ((aa % nb) != 0) || ((a & 32'hF000_0000) != 32'h8000_0000);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    int nb = 1 << s;
    int base = int'(a[5:0]);
    logic [31:0] v = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int nb = 1 << s;
    int base = int'(a[5:0]);
    for (int i = 0; i < nb; i++) ref_mem[base + i] = 8'(d >> (8 * i));
  endfunction

  typedef struct {
    logic        ready_at_start;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cycles;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        touched;
    logic        unstable;
    logic        ready_low;
    logic        io_idle;
    logic        stable;
    logic        rdy_after;
  } obs_t;

  // Drives one request starting at a negedge and ends at the negedge after the response handshake.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input int hold, output obs_t o);
    o.ready_at_start = req_ready;
    o.rdata = '0; o.err = 1'b0; o.lat = 0; o.we_cycles = 0;
    o.bus_addr = '0; o.bus_be = '0; o.bus_wdata = '0;
    o.touched = 1'b0; o.unstable = 1'b0; o.ready_low = 1'b1;
    o.io_idle = 1'b0; o.stable = 1'b1; o.rdy_after = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    o.lat = 1;
    while (!rsp_valid && o.lat < 20) begin
      if (o.lat == 1) begin
        o.bus_addr = io_addr; o.bus_be = io_be;
      end else if (io_addr !== o.bus_addr || io_be !== o.bus_be) o.unstable = 1'b1;
      if (io_we) begin o.we_cycles++; o.bus_wdata = io_wdata; end
      if (io_addr != 0) o.touched = 1'b1;
      if (req_ready) o.ready_low = 1'b0;
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
      req_size = 2'($urandom); req_wdata = $urandom;
      @(negedge clk);
      o.lat++;
    end
    o.rdata = rsp_rdata;
    o.err = rsp_err;
    if (io_we) o.we_cycles++;
    if (io_addr != 0) o.touched = 1'b1;
    if (req_ready) o.ready_low = 1'b0;
    o.io_idle = (io_addr == 0) && (io_be == 0) && (io_wdata == 0) && !io_we;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== o.rdata || rsp_err !== o.err || req_ready) o.stable = 1'b0;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o.rdy_after = req_ready && !rsp_valid;
  endtask

  task automatic test_reset();
    n_vec++; if ({req_ready, rsp_valid, rsp_err, io_we, io_be} !== 8'b1000_0000) begin n_err++; $display("FAIL reset_ctrl got %b exp 10000000", {req_ready, rsp_valid, rsp_err, io_we, io_be}); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
    n_vec++; if (io_addr !== 32'h0 || io_wdata !== 32'h0) begin n_err++; $display("FAIL reset_io got addr %h wdata %h exp 0", io_addr, io_wdata); end
  endtask

  task automatic test_prefill();
    obs_t o;
    logic [31:0] d;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      run_txn(1'b1, 32'h8000_0000 + 32'(4 * w), 2'd2, 1'b0, d, 0, o);
      ref_store(32'h8000_0000 + 32'(4 * w), 2'd2, d);
      n_vec++; if (o.we_cycles != 1 || o.err !== 1'b0) begin n_err++; $display("FAIL prefill_%0d got we %0d err %b exp 1 0", w, o.we_cycles, o.err); end
    end
  endtask

  task automatic test_store_word();
    obs_t o;
    run_txn(1'b1, 32'h8000_0014, 2'd2, 1'b0, 32'h0000_0001, 0, o);
    ref_store(32'h8000_0014, 2'd2, 32'h0000_0001);
    n_vec++; if (o.we_cycles != 1) begin n_err++; $display("FAIL sw_we_cycles got %0d exp 1", o.we_cycles); end
    n_vec++; if (o.bus_addr !== 32'h8000_0014 || o.bus_be !== 4'b1111) begin n_err++; $display("FAIL sw_bus got %h/%b exp 80000014/1111", o.bus_addr, o.bus_be); end
    n_vec++; if (o.bus_wdata !== 32'h0000_0001) begin n_err++; $display("FAIL sw_wdata got %h exp 00000001", o.bus_wdata); end
    n_vec++; if (o.lat != 2 || o.err !== 1'b0 || o.rdata !== 32'h0) begin n_err++; $display("FAIL sw_rsp got lat %0d err %b rd %h exp 2 0 0", o.lat, o.err, o.rdata); end
    n_vec++; if (!o.io_idle || !o.rdy_after || !o.ready_low) begin n_err++; $display("FAIL sw_ctrl got idle %b rdy %b low %b exp 1 1 1", o.io_idle, o.rdy_after, o.ready_low); end
  endtask

  task automatic test_store_byte();
    obs_t o;
    run_txn(1'b1, 32'h8000_0011, 2'd0, 1'b0, 32'h0000_00A5, 0, o);
    ref_store(32'h8000_0011, 2'd0, 32'h0000_00A5);
    n_vec++; if (o.bus_addr !== 32'h8000_0010 || o.bus_be !== 4'b0010) begin n_err++; $display("FAIL sb_bus got %h/%b exp 80000010/0010", o.bus_addr, o.bus_be); end
    n_vec++; if (o.bus_wdata !== 32'hA5A5_A5A5 || o.we_cycles != 1) begin n_err++; $display("FAIL sb_wdata got %h we %0d exp a5a5a5a5 1", o.bus_wdata, o.we_cycles); end
  endtask

  task automatic test_loads();
    obs_t o;
    logic [31:0] ad [3] = '{32'h8000_0000, 32'h8000_0001, 32'h8000_0000};
    logic [1:0]  sz [3] = '{2'd0, 2'd0, 2'd1};
    logic        un [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ex [3] = '{32'hFFFF_FF80, 32'h0000_00F0, 32'hFFFF_F080};
    logic [3:0]  be [3] = '{4'b0001, 4'b0010, 4'b0011};
    fixed_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, ad[i], sz[i], un[i], 32'h0, 0, o);
      n_vec++; if (o.rdata !== ex[i] || o.err !== 1'b0) begin n_err++; $display("FAIL load_%0d_data got %h err %b exp %h 0", i, o.rdata, o.err, ex[i]); end
      n_vec++; if (o.lat != 3 || o.we_cycles != 0) begin n_err++; $display("FAIL load_%0d_timing got lat %0d we %0d exp 3 0", i, o.lat, o.we_cycles); end
      n_vec++; if (o.bus_addr !== 32'h8000_0000 || o.bus_be !== be[i] || o.unstable) begin n_err++; $display("FAIL load_%0d_bus got %h/%b unstable %b exp 80000000/%b", i, o.bus_addr, o.bus_be, o.unstable, be[i]); end
    end
    fixed_rd = 1'b0;
  endtask

  task automatic test_errors();
    obs_t o;
    logic [31:0] ad [4] = '{32'h8000_0002, 32'h8000_0003, 32'h8000_0000, 32'h0000_1000};
    logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic        we [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_txn(we[i], ad[i], sz[i], 1'b0, 32'hDEAD_BEEF, 0, o);
      n_vec++; if (o.err !== 1'b1 || o.rdata !== 32'h0) begin n_err++; $display("FAIL err_%0d_rsp got err %b rd %h exp 1 0", i, o.err, o.rdata); end
      n_vec++; if (o.we_cycles != 0 || o.touched || o.lat != 1) begin n_err++; $display("FAIL err_%0d_bus got we %0d touched %b lat %0d exp 0 0 1", i, o.we_cycles, o.touched, o.lat); end
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    logic [31:0] d;
    fixed_rd = 1'b1;
    run_txn(1'b0, 32'h8000_0000, 2'd0, 1'b0, 32'h0, 4, o);
    fixed_rd = 1'b0;
    n_vec++; if (!o.stable || !o.ready_low) begin n_err++; $display("FAIL bp_hold got stable %b ready_low %b exp 1 1", o.stable, o.ready_low); end
    n_vec++; if (o.rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL bp_rdata got %h exp ffffff80", o.rdata); end
    n_vec++; if (!o.rdy_after) begin n_err++; $display("FAIL bp_release got %b exp 1", o.rdy_after); end
    d = $urandom;
    run_txn(1'b1, 32'h8000_0020, 2'd2, 1'b0, d, 0, o);
    ref_store(32'h8000_0020, 2'd2, d);
    n_vec++; if (!o.ready_at_start || o.lat != 2 || o.we_cycles != 1) begin n_err++; $display("FAIL bp_next got rdy %b lat %0d we %0d exp 1 2 1", o.ready_at_start, o.lat, o.we_cycles); end
  endtask

  task automatic test_reset_mid_read();
    obs_t o;
    logic quiet;
    logic [31:0] d;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0004; req_size = 2'd2;
    req_unsigned = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++; if (io_addr !== 32'h8000_0004 || req_ready !== 1'b0) begin n_err++; $display("FAIL rst_pre got addr %h rdy %b exp 80000004 0", io_addr, req_ready); end
    #2 reset = 1'b0;
    #1;
    n_vec++; if ({req_ready, rsp_valid, rsp_err, io_we, io_be} !== 8'b1000_0000) begin n_err++; $display("FAIL rst_mid_ctrl got %b exp 10000000", {req_ready, rsp_valid, rsp_err, io_we, io_be}); end
    n_vec++; if (io_addr !== 32'h0 || rsp_rdata !== 32'h0 || io_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_data got %h %h %h exp 0", io_addr, rsp_rdata, io_wdata); end
    #1 reset = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid || io_addr != 0) quiet = 1'b0;
    end
    n_vec++; if (!quiet) begin n_err++; $display("FAIL rst_quiet got %b exp 1", quiet); end
    d = $urandom;
    run_txn(1'b1, 32'h8000_0008, 2'd2, 1'b0, d, 0, o);
    ref_store(32'h8000_0008, 2'd2, d);
    n_vec++; if (o.lat != 2 || o.we_cycles != 1 || o.err !== 1'b0 || o.bus_wdata !== d) begin n_err++; $display("FAIL rst_store got lat %0d we %0d err %b wd %h exp 2 1 0 %h", o.lat, o.we_cycles, o.err, o.bus_wdata, d); end
  endtask

  task automatic test_random();
    obs_t o;
    logic        we, uns, e_err;
    logic [1:0]  sz;
    logic [31:0] ad, wd, e_rd;
    int          e_lat;
    for (int i = 0; i < 80; i++) begin
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad  = {($urandom_range(0, 7) == 0) ? 4'h4 : 4'h8, 22'd0, 6'($urandom_range(0, 63))};
      wd  = $urandom;
      e_err = ref_err(ad, sz);
      e_rd  = (!e_err && !we) ? ref_load(ad, sz, uns) : 32'h0;
      e_lat = e_err ? 1 : (we ? 2 : 3);
      run_txn(we, ad, sz, uns, wd, $urandom_range(0, 2), o);
      if (!e_err && we) ref_store(ad, sz, wd);
      n_vec++; if (o.err !== e_err || o.rdata !== e_rd) begin n_err++; $display("FAIL rnd_%0d_rsp addr %h sz %0d we %b got err %b rd %h exp %b %h", i, ad, sz, we, o.err, o.rdata, e_err, e_rd); end
      n_vec++; if (o.lat != e_lat || o.we_cycles != ((!e_err && we) ? 1 : 0) || !o.stable) begin n_err++; $display("FAIL rnd_%0d_timing got lat %0d we %0d stable %b exp %0d", i, o.lat, o.we_cycles, o.stable, e_lat); end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_prefill();
    test_store_word();
    test_store_byte();
    test_loads();
    test_errors();
    test_backpressure();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
